// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of a 5-stage RV32I pipeline.
//
// Holds the PC, issues one-at-a-time requests to a variable-latency
// instruction memory and loads the IF/ID pipeline register.
//
// Ports
//   CLK, RST_n            clock (rising edge), async active-low reset
//   PCWrite, IF_IDWrite   hazard-unit stall controls (advance only when both 1)
//   Redirect, RedirectPC  taken branch/jump: flush IF/ID and refetch target
//   IMem_req, IMem_addr   memory request / word-aligned request address
//   IMem_rdata, IMem_valid returned instruction / response strobe
//   PC_ID, Instr_ID, Valid_ID  IF/ID register contents
//   ControlBubble         ~Valid_ID, for the hazard unit
//   state_dbg             current fetch FSM state (debug visibility)
//
// Memory handshake: a request is open while IMem_req=1; IMem_req and
// IMem_addr stay stable until (and including) the cycle IMem_valid=1, which
// closes it. IMem_valid while no request is open is ignored.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic            PCWrite,
  input  logic            IF_IDWrite,
  input  logic            Redirect,
  input  logic [XLEN-1:0] RedirectPC,
  output logic            IMem_req,
  output logic [XLEN-1:0] IMem_addr,
  input  logic [31:0]     IMem_rdata,
  input  logic            IMem_valid,
  output logic [XLEN-1:0] PC_ID,
  output logic [31:0]     Instr_ID,
  output logic            Valid_ID,
  output logic            ControlBubble,
  output logic [1:0]      state_dbg
);

  // REQ : request open for req_addr
  // HOLD: response captured in buf while stalled; no request open
  // DROP: request open but its response is stale (redirect happened)
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [31:0]     buf_q, buf_d;
  logic [XLEN-1:0] pc_id_q, pc_id_d;
  logic [31:0]     instr_id_q, instr_id_d;
  logic            valid_id_q, valid_id_d;

  logic            adv;
  logic [XLEN-1:0] redirect_tgt;
  logic            deliver;
  logic [XLEN-1:0] deliver_pc;
  logic [31:0]     deliver_instr;

  assign adv          = PCWrite & IF_IDWrite;
  assign redirect_tgt = RedirectPC & ~XLEN'(3);

  // Fetch FSM: next state, PC, request address, hold buffer
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    buf_d         = buf_q;
    deliver       = 1'b0;
    deliver_pc    = req_addr_q;
    deliver_instr = IMem_rdata;
    case (state_q)
      S_REQ: begin
        if (Redirect && IMem_valid) begin
          // request closes this cycle, so the target can go out next cycle
          pc_d       = redirect_tgt;
          req_addr_d = redirect_tgt;
        end else if (Redirect) begin
          // request still open: keep its address until the stale reply lands
          pc_d    = redirect_tgt;
          state_d = S_DROP;
        end else if (IMem_valid && adv) begin
          deliver    = 1'b1;
          pc_d       = pc_q + XLEN'(4);
          req_addr_d = pc_q + XLEN'(4);
        end else if (IMem_valid) begin
          buf_d   = IMem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          buf_d      = '0;
          pc_d       = redirect_tgt;
          req_addr_d = redirect_tgt;
          state_d    = S_REQ;
        end else if (adv) begin
          deliver       = 1'b1;
          deliver_pc    = pc_q;
          deliver_instr = buf_q;
          pc_d          = pc_q + XLEN'(4);
          req_addr_d    = pc_q + XLEN'(4);
          state_d       = S_REQ;
        end
      end
      S_DROP: begin
        if (Redirect) pc_d = redirect_tgt;
        if (IMem_valid) begin
          req_addr_d = Redirect ? redirect_tgt : pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // IF/ID register: redirect flush beats the stall
  always_comb begin
    pc_id_d    = pc_id_q;
    instr_id_d = instr_id_q;
    valid_id_d = valid_id_q;
    if (Redirect) begin
      valid_id_d = 1'b0;
      instr_id_d = NOP_INSTR;
    end else if (!IF_IDWrite) begin
      // hold
    end else if (deliver) begin
      pc_id_d    = deliver_pc;
      instr_id_d = deliver_instr;
      valid_id_d = 1'b1;
    end else begin
      valid_id_d = 1'b0;
      instr_id_d = NOP_INSTR;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_q      <= '0;
      pc_id_q    <= '0;
      instr_id_q <= NOP_INSTR;
      valid_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
      pc_id_q    <= pc_id_d;
      instr_id_q <= instr_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  // No request may be seen while reset is asserted
  assign IMem_req      = RST_n & (state_q != S_HOLD);
  assign IMem_addr     = req_addr_q;
  assign PC_ID         = pc_id_q;
  assign Instr_ID      = instr_id_q;
  assign Valid_ID      = valid_id_q;
  assign ControlBubble = ~valid_id_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage : self-checking bench for if_stage.
// Directed vector table, async reset check, then randomized traffic checked
// against a transaction-level fetch model.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        PCWrite = 1'b0, IF_IDWrite = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] RedirectPC = '0;
  logic        IMem_req;
  logic [31:0] IMem_addr;
  logic [31:0] IMem_rdata = '0;
  logic        IMem_valid = 1'b0;
  logic [31:0] PC_ID;
  logic [31:0] Instr_ID;
  logic        Valid_ID;
  logic        ControlBubble;
  logic [1:0]  state_dbg;

  always #5 CLK = ~CLK;

  if_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .RST_n(RST_n), .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite),
    .Redirect(Redirect), .RedirectPC(RedirectPC), .IMem_req(IMem_req),
    .IMem_addr(IMem_addr), .IMem_rdata(IMem_rdata), .IMem_valid(IMem_valid),
    .PC_ID(PC_ID), .Instr_ID(Instr_ID), .Valid_ID(Valid_ID),
    .ControlBubble(ControlBubble), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit adv, input bit r, input logic [31:0] t,
                       input bit v, input logic [31:0] d);
    PCWrite    = adv;
    IF_IDWrite = adv;
    Redirect   = r;
    RedirectPC = t;
    IMem_valid = v;
    IMem_rdata = d;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          adv;
    bit          redir;
    logic [31:0] rpc;
    bit          v;
    logic [31:0] rdata;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_vid;
    logic [31:0] e_instr;
    logic [31:0] e_pcid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit adv, input bit r, input logic [31:0] t, input bit v,
                     input logic [31:0] d, input bit ereq, input logic [31:0] eaddr,
                     input bit evid, input logic [31:0] einstr, input logic [31:0] epcid);
    vec_t x;
    x.adv = adv; x.redir = r; x.rpc = t; x.v = v; x.rdata = d;
    x.e_req = ereq; x.e_addr = eaddr; x.e_vid = evid; x.e_instr = einstr; x.e_pcid = epcid;
    vecs.push_back(x);
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_pc, m_raddr;
  bit          m_stale;          // open request's reply must be thrown away
  logic [31:0] m_buf[$];         // instruction fetched but not yet accepted
  logic [31:0] m_pcid, m_instr;
  bit          m_vid;

  task automatic model_reset();
    m_pc = 0; m_raddr = 0; m_stale = 0; m_buf.delete();
    m_pcid = 0; m_instr = NOP; m_vid = 0;
  endtask

  task automatic model_step(input bit adv, input bit r, input logic [31:0] t,
                            input bit v, input logic [31:0] d);
    bit          dlv  = 0;
    logic [31:0] dpc  = 0;
    logic [31:0] dins = 0;
    logic [31:0] ta   = t & 32'hFFFF_FFFC;
    if (m_buf.size() != 0) begin
      if (r) begin
        m_buf.delete(); m_pc = ta; m_raddr = ta;
      end else if (adv) begin
        dlv = 1; dpc = m_pc; dins = m_buf.pop_front();
        m_pc = m_pc + 4; m_raddr = m_pc;
      end
    end else if (m_stale) begin
      if (r) m_pc = ta;
      if (v) begin m_raddr = m_pc; m_stale = 0; end
    end else begin
      if (r && v) begin
        m_pc = ta; m_raddr = ta;
      end else if (r) begin
        m_pc = ta; m_stale = 1;
      end else if (v && adv) begin
        dlv = 1; dpc = m_raddr; dins = d;
        m_pc = m_raddr + 4; m_raddr = m_pc;
      end else if (v) begin
        m_buf.push_back(d);
      end
    end
    if (r) begin
      m_vid = 0; m_instr = NOP;
    end else if (!adv) begin
      // stalled: IF/ID keeps its contents
    end else if (dlv) begin
      m_vid = 1; m_instr = dins; m_pcid = dpc;
    end else begin
      m_vid = 0; m_instr = NOP;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},    {31'b0, IMem_req},      32'd0);
    check({tag, "_addr"},   IMem_addr,              32'h0);
    check({tag, "_pcid"},   PC_ID,                  32'h0);
    check({tag, "_instr"},  Instr_ID,               NOP);
    check({tag, "_vid"},    {31'b0, Valid_ID},      32'd0);
    check({tag, "_bubble"}, {31'b0, ControlBubble}, 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Directed table: inputs applied for one cycle, outputs checked after it.
    //   adv red rpc            v  rdata          req addr          vid instr          pcid
    add(1, 0, 32'h0,          0, 32'h0,         1, 32'h0,         0, NOP,          32'h0);   // first issue
    add(1, 0, 32'h0,          1, 32'h3,         1, 32'h4,         1, 32'h3,        32'h0);
    add(1, 0, 32'h0,          0, 32'h0,         1, 32'h4,         0, NOP,          32'h0);
    add(1, 0, 32'h0,          1, 32'h7,         1, 32'h8,         1, 32'h7,        32'h4);
    add(1, 0, 32'h0,          0, 32'h0,         1, 32'h8,         0, NOP,          32'h4);
    add(0, 0, 32'h0,          1, 32'hB,         0, 32'h8,         0, NOP,          32'h4);   // stall -> hold
    add(0, 0, 32'h0,          0, 32'h0,         0, 32'h8,         0, NOP,          32'h4);
    add(0, 0, 32'h0,          1, 32'hDEAD,      0, 32'h8,         0, NOP,          32'h4);   // stray valid in hold
    add(1, 0, 32'h0,          0, 32'h0,         1, 32'hC,         1, 32'hB,        32'h8);   // release
    add(1, 0, 32'h0,          0, 32'h0,         1, 32'hC,         0, NOP,          32'h8);
    add(1, 0, 32'h0,          1, 32'hF,         1, 32'h10,        1, 32'hF,        32'hC);
    add(1, 0, 32'h0,          0, 32'h0,         1, 32'h10,        0, NOP,          32'hC);
    add(1, 1, 32'h100,        0, 32'h0,         1, 32'h10,        0, NOP,          32'hC);   // redirect, req open
    add(1, 0, 32'h0,          0, 32'h0,         1, 32'h10,        0, NOP,          32'hC);
    add(1, 0, 32'h0,          1, 32'h13,        1, 32'h100,       0, NOP,          32'hC);   // stale reply dropped
    add(1, 0, 32'h0,          0, 32'h0,         1, 32'h100,       0, NOP,          32'hC);
    add(1, 0, 32'h0,          1, 32'h103,       1, 32'h104,       1, 32'h103,      32'h100);
    add(1, 1, 32'h203,        1, 32'hBAD,       1, 32'h200,       0, NOP,          32'h100); // redirect + valid
    add(0, 0, 32'h0,          1, 32'h203,       0, 32'h200,       0, NOP,          32'h100); // hold
    add(0, 1, 32'h40,         0, 32'h0,         1, 32'h40,        0, NOP,          32'h100); // redirect in hold
    add(1, 0, 32'h0,          1, 32'h43,        1, 32'h44,        1, 32'h43,       32'h40);
    add(1, 1, 32'hFFFF_FFFC,  0, 32'h0,         1, 32'h44,        0, NOP,          32'h40);
    add(1, 0, 32'h0,          1, 32'h1,         1, 32'hFFFF_FFFC, 0, NOP,          32'h40);
    add(1, 0, 32'h0,          1, 32'h77,        1, 32'h0,         1, 32'h77,       32'hFFFF_FFFC); // wrap

    // reset held
    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    check_reset_vals("rst");

    RST_n = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i].adv, vecs[i].redir, vecs[i].rpc, vecs[i].v, vecs[i].rdata);
      @(negedge CLK);
      check($sformatf("v%0d_req", i),    {31'b0, IMem_req},      {31'b0, vecs[i].e_req});
      check($sformatf("v%0d_addr", i),   IMem_addr,              vecs[i].e_addr);
      check($sformatf("v%0d_vid", i),    {31'b0, Valid_ID},      {31'b0, vecs[i].e_vid});
      check($sformatf("v%0d_bubble", i), {31'b0, ControlBubble}, {31'b0, ~vecs[i].e_vid});
      check($sformatf("v%0d_instr", i),  Instr_ID,               vecs[i].e_instr);
      check($sformatf("v%0d_pcid", i),   PC_ID,                  vecs[i].e_pcid);
    end

    // Mid-request async reset: request for 0x0 is open, IF/ID holds 0x77
    drive(1, 0, 0, 0, 0);
    #2 RST_n = 1'b0;
    #1 check_reset_vals("arst");
    IMem_valid = 1'b1;           // stray response while reset is held
    IMem_rdata = 32'h1234_5678;
    @(negedge CLK);
    drive(1, 0, 0, 0, 0);
    RST_n = 1'b1;
    @(negedge CLK);
    check("post_rst_req",   {31'b0, IMem_req}, 32'd1);
    check("post_rst_addr",  IMem_addr,         32'h0);
    check("post_rst_vid",   {31'b0, Valid_ID}, 32'd0);
    check("post_rst_instr", Instr_ID,          NOP);

    // Randomized traffic versus the model (DUT is one idle cycle past reset)
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit          adv, r, v;
      logic [31:0] t, d;
      bit          m_req;
      m_req = (m_buf.size() == 0);
      check("rnd_req",    {31'b0, IMem_req},      {31'b0, m_req});
      if (m_req) check("rnd_addr", IMem_addr, m_raddr);
      check("rnd_vid",    {31'b0, Valid_ID},      {31'b0, m_vid});
      check("rnd_bubble", {31'b0, ControlBubble}, {31'b0, ~m_vid});
      check("rnd_instr",  Instr_ID,               m_instr);
      check("rnd_pcid",   PC_ID,                  m_pcid);
      adv = ($urandom_range(0, 9) < 7);
      r   = ($urandom_range(0, 9) == 0);
      t   = $urandom;
      if (($urandom_range(0, 19) == 0)) t = 32'hFFFF_FFFC | $urandom_range(0, 3);
      v   = m_req ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 2);
      d   = $urandom;
      drive(adv, r, t, v, d);
      model_step(adv, r, t, v, d);
      @(negedge CLK);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline. Holds the PC and issues requests to a variable-latency instruction memory.
- Drives the IF/ID pipeline register and is stalled by the hazard unit's PCWrite/IF_IDWrite.
- Flushed by branch/jump redirects resolved downstream.
- Produces ControlBubble, which the hazard unit consumes to squash control for non-valid IF/ID slots.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, Instr_ID value when the slot is empty (addi x0,x0,0)

Ports:
CLK  input  1  clock, rising edge
RST_n  input  1  asynchronous active-low reset
PCWrite  input  1  hazard unit: PC may advance
IF_IDWrite  input  1  hazard unit: IF/ID may load
Redirect  input  1  taken branch/jump; flush and refetch
RedirectPC  input  XLEN  redirect target
IMem_req  output  1  instruction-memory request
IMem_addr  output  XLEN  request address, word-aligned
IMem_rdata  input  32  returned instruction
IMem_valid  input  1  IMem_rdata valid this cycle
PC_ID  output  XLEN  IF/ID: PC of held instruction
Instr_ID  output  32  IF/ID: instruction
Valid_ID  output  1  IF/ID slot holds a real instruction
ControlBubble  output  1  equals ~Valid_ID, combinational

Behaviour:
- Reset (async, RST_n=0):
  - PC=RESET_PC, state=REQ, PC_ID=0, Instr_ID=NOP_INSTR, Valid_ID=0, ControlBubble=1.
  - Hold buffer cleared. IMem_req forced 0 while RST_n=0.
  - First request is issued in the first cycle after release.
- Definitions:
  - adv = PCWrite & IF_IDWrite. The two are driven identically; the block only advances when both are 1.
  - RedirectPC[1:0] is forced to 00 on capture.
- Memory handshake:
  - At most one outstanding request.
  - IMem_req and IMem_addr stay stable from issue until the cycle IMem_valid=1 inclusive.
  - IMem_valid outside an outstanding request is ignored.
  - IMem_addr comes from a req_addr register, not from the live PC.
- State REQ (IMem_req=1, IMem_addr=req_addr):
  - Redirect & IMem_valid: discard response; PC=req_addr=RedirectPC; stay REQ.
  - Redirect & !IMem_valid: PC=RedirectPC; go to DROP.
  - IMem_valid & adv: IF/ID <= {req_addr, IMem_rdata, 1}; PC=req_addr=PC+4; stay REQ. The next request is issued the following cycle.
  - IMem_valid & !adv: buffer <= IMem_rdata; go to HOLD.
  - Otherwise: wait.
- State HOLD (IMem_req=0):
  - Redirect: clear buffer; PC=req_addr=RedirectPC; go to REQ.
  - adv: IF/ID <= {PC, buffer, 1}; PC=req_addr=PC+4; go to REQ.
  - Otherwise: hold.
- State DROP (IMem_req=1, old req_addr held):
  - IMem_valid: discard; req_addr=PC; go to REQ.
  - Redirect in DROP: PC=RedirectPC; stay DROP.
  - Redirect and IMem_valid together: discard; req_addr=RedirectPC; go to REQ.
- IF/ID register, priority high to low:
  1. Redirect: Valid_ID=0, Instr_ID=NOP_INSTR. This flush applies even when IF_IDWrite=0.
  2. IF_IDWrite=0: hold all fields.
  3. Instruction delivered this cycle: load it.
  4. Otherwise: Valid_ID=0, Instr_ID=NOP_INSTR, PC_ID unchanged (bubble).
- Arithmetic: PC+4 wraps modulo 2^XLEN; 32'hFFFF_FFFC+4 = 0.
- Throughput and latency:
  - With 1-cycle memory (IMem_valid the cycle after issue) and no stalls: one instruction every 2 cycles.
  - Instruction appears in IF/ID the cycle after IMem_valid.
- Reset mid-request: state, PC and IF/ID return to reset values immediately. A late IMem_valid after release with no outstanding request is ignored.

Test Plan:
- Reset then release; IMem_valid 1 cycle after each request with rdata=addr|0x3, adv=1 → IMem_addr sequence 0,4,8; Instr_ID 0x3,0x7,0xB with PC_ID 0,4,8; ControlBubble=0 only in the cycles those are loaded.
- Response at PC=8 arrives with PCWrite=IF_IDWrite=0 for 3 cycles → state HOLD, IMem_req=0, IF/ID unchanged. On release Instr_ID=0xB, PC_ID=8, next IMem_addr=0xC.
- Redirect to 0x100 while the request for 0x10 is outstanding; IMem_valid 2 cycles later → response discarded, Valid_ID=0, next IMem_addr=0x100, Instr_ID later = rdata of 0x100.
- Redirect to 0x203 in the same cycle as IMem_valid with adv=1 → response discarded, IF/ID flushed (Instr_ID=0x13, ControlBubble=1), next IMem_addr=0x200.
- Redirect to 0x40 during HOLD with IF_IDWrite=0 → Valid_ID=0 next cycle despite stall, buffer dropped, IMem_addr=0x40.
- Redirect to 0xFFFF_FFFC then one delivered fetch → next IMem_addr=0. RST_n pulsed low mid-request → outputs at reset values asynchronously; a stray IMem_valid after release has no effect.
